gpio_irq_ctrl: RTL and testbench

- Parametrised successor of the SIWA GPIO wrapper logic.
- Provides N_GPIO bidirectional pins, each with its own direction and output registers.
- Inputs pass through a synchroniser and a programmable debounce filter.
- Each pin has a configurable edge/level interrupt, with pending, mask and an aggregated machine interrupt line (maip) to the core.
- Sits between the core register bus and the pad level shifters.

---
 rtl/gpio_pkg.sv | 32 +++
 rtl/gpio_in_filter.sv | 60 ++++++
 rtl/gpio_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and interrupt mode encoding shared by the GPIO block
package gpio_pkg;

   localparam logic [2:0] ADDR_EN   = 3'd0;
   localparam logic [2:0] ADDR_OUT  = 3'd1;
   localparam logic [2:0] ADDR_IN   = 3'd2;
   localparam logic [2:0] ADDR_IE   = 3'd3;
   localparam logic [2:0] ADDR_MODE = 3'd4;
   localparam logic [2:0] ADDR_PEND = 3'd5;
   localparam logic [2:0] ADDR_DEB  = 3'd6;

   typedef enum logic [1:0] {
      IRQ_RISE = 2'b00,
      IRQ_FALL = 2'b01,
      IRQ_BOTH = 2'b10,
      IRQ_HIGH = 2'b11
   } irq_mode_e;

   function automatic logic mode_event(input irq_mode_e mode, input logic lvl,
                                       input logic rise, input logic fall);
      logic ev;
      case (mode)
         IRQ_RISE: ev = rise;
         IRQ_FALL: ev = fall;
         IRQ_BOTH: ev = rise | fall;
         IRQ_HIGH: ev = lvl;
         default:  ev = 1'b0;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - one pin: synchroniser, debounce filter and edge detector
module gpio_in_filter
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             pad_i,
   input  logic [DEB_W-1:0] deb_i,
   output logic             level_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   filt_q, filt_d;
   logic                   prev_q;
   logic [DEB_W-1:0]       cnt_q, cnt_d, cnt_inc;

   assign synced = sync_q[SYNC_STAGES-1];

   // The counter counts cycles of disagreement including the current one, so the
   // filtered value follows exactly deb_i cycles after the synced value changes.
   always_comb begin
      cnt_inc = (cnt_q == {DEB_W{1'b1}}) ? cnt_q : cnt_q + DEB_W'(1);
      filt_d  = filt_q;
      cnt_d   = '0;
      if (deb_i == '0) begin
         filt_d = synced;
      end else if (synced != filt_q) begin
         if (cnt_inc == deb_i) begin
            filt_d = synced;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
         filt_q <= filt_d;
         prev_q <= filt_q;
         cnt_q  <= cnt_d;
      end
   end

   assign level_o = filt_q;
   assign rise_o  = filt_q & ~prev_q;
   assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO block: direction/output registers, filtered inputs,
// per-pin edge/level interrupts with pending, mask and aggregated maip.
module gpio_irq_ctrl
   import gpio_pkg::*;
#(
   parameter int N_GPIO      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_GPIO-1:0] gpio_in,
   output logic [N_GPIO-1:0] gpio_out,
   output logic [N_GPIO-1:0] gpio_oe,
   input  logic [2:0]        bus_addr,
   input  logic              bus_wr,
   input  logic              bus_rd,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic [DATA_W-1:0] bus_rdata,
   output logic              bus_rvalid,
   output logic              maip
);

   logic [N_GPIO-1:0]   en_q, en_d;
   logic [N_GPIO-1:0]   out_q, out_d;
   logic [N_GPIO-1:0]   ie_q, ie_d;
   logic [N_GPIO-1:0]   pend_q, pend_d;
   logic [2*N_GPIO-1:0] mode_q, mode_d;
   logic [DEB_W-1:0]    deb_q, deb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q;
   logic                maip_q;
   logic [N_GPIO-1:0]   lvl, rise, fall, evt, w1c;
   logic                unused_wdata;

   assign unused_wdata = ^bus_wdata;

   for (genvar g = 0; g < N_GPIO; g++) begin : g_pin
      gpio_in_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_W       (DEB_W)
      ) u_filt (
         .clk     (clk),
         .rst_ni  (reset),
         .pad_i   (gpio_in[g]),
         .deb_i   (deb_q),
         .level_o (lvl[g]),
         .rise_o  (rise[g]),
         .fall_o  (fall[g])
      );
   end

   // Output-enabled pins never raise events; their pending bits are left alone.
   always_comb begin
      evt = '0;
      for (int i = 0; i < N_GPIO; i++) begin
         evt[i] = mode_event(irq_mode_e'(mode_q[2*i +: 2]), lvl[i], rise[i], fall[i]);
      end
      evt = evt & ~en_q;
   end

   always_comb begin
      en_d   = en_q;
      out_d  = out_q;
      ie_d   = ie_q;
      mode_d = mode_q;
      deb_d  = deb_q;
      w1c    = '0;
      if (bus_wr) begin
         case (bus_addr)
            ADDR_EN:   en_d   = bus_wdata[N_GPIO-1:0];
            ADDR_OUT:  out_d  = bus_wdata[N_GPIO-1:0];
            ADDR_IE:   ie_d   = bus_wdata[N_GPIO-1:0];
            ADDR_MODE: mode_d = bus_wdata[2*N_GPIO-1:0];
            ADDR_PEND: w1c    = bus_wdata[N_GPIO-1:0];
            ADDR_DEB:  deb_d  = bus_wdata[DEB_W-1:0];
            default:   ;
         endcase
      end
      // A new event outranks a clear of the same bit in the same cycle.
      pend_d = (pend_q & ~w1c) | evt;
   end

   always_comb begin
      rdata_d = '0;
      if (bus_rd) begin
         case (bus_addr)
            ADDR_EN:   rdata_d[N_GPIO-1:0]   = en_q;
            ADDR_OUT:  rdata_d[N_GPIO-1:0]   = out_q;
            ADDR_IN:   rdata_d[N_GPIO-1:0]   = lvl;
            ADDR_IE:   rdata_d[N_GPIO-1:0]   = ie_q;
            ADDR_MODE: rdata_d[2*N_GPIO-1:0] = mode_q;
            ADDR_PEND: rdata_d[N_GPIO-1:0]   = pend_q;
            ADDR_DEB:  rdata_d[DEB_W-1:0]    = deb_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q     <= '0;
         out_q    <= '0;
         ie_q     <= '0;
         pend_q   <= '0;
         mode_q   <= '0;
         deb_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         maip_q   <= 1'b0;
      end else begin
         en_q     <= en_d;
         out_q    <= out_d;
         ie_q     <= ie_d;
         pend_q   <= pend_d;
         mode_q   <= mode_d;
         deb_q    <= deb_d;
         rdata_q  <= rdata_d;
         rvalid_q <= bus_rd;
         maip_q   <= |(pend_q & ie_q);
      end
   end

   assign gpio_out   = out_q;
   assign gpio_oe    = en_q;
   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign maip       = maip_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - self-checking bench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

   localparam int N  = 8;
   localparam int SS = 2;
   localparam int DW = 8;
   localparam int XW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  gpio_in;
   logic [N-1:0]  gpio_out, gpio_oe;
   logic [2:0]    bus_addr;
   logic          bus_wr, bus_rd;
   logic [XW-1:0] bus_wdata, bus_rdata;
   logic          bus_rvalid, maip;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gpio_irq_ctrl #(.N_GPIO(N), .SYNC_STAGES(SS), .DEB_W(DW), .DATA_W(XW)) dut (
      .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
      .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .maip(maip)
   );

   // Reference model: whole-block state advanced once per clock from the register-map rules.
   typedef struct packed {
      logic [N-1:0]          en, out, ie, pend, filt, prev;
      logic [2*N-1:0]        mode;
      logic [DW-1:0]         deb;
      logic                  maip, rvalid;
      logic [XW-1:0]         rdata;
      logic [SS-1:0][N-1:0]  hist;
      logic [N-1:0][DW-1:0]  run;
   } model_t;

   model_t m;

   function automatic model_t model_next(input model_t c, input logic [N-1:0] pad,
                                         input logic wr, input logic rd,
                                         input logic [2:0] a, input logic [XW-1:0] wd);
      model_t n;
      logic [N-1:0] din, ev, nf;
      logic rs, fl, e;
      n    = c;
      din  = c.hist[SS-1];
      n.hist = {c.hist[SS-2:0], pad};
      nf   = c.filt;
      ev   = '0;
      for (int i = 0; i < N; i++) begin
         rs = c.filt[i] && !c.prev[i];
         fl = !c.filt[i] && c.prev[i];
         case (c.mode[2*i +: 2])
            2'd0:    e = rs;
            2'd1:    e = fl;
            2'd2:    e = rs || fl;
            default: e = c.filt[i];
         endcase
         ev[i] = e && !c.en[i];
         if (c.deb == '0) begin
            nf[i] = din[i];
            n.run[i] = '0;
         end else if (din[i] != c.filt[i]) begin
            if (c.run[i] != {DW{1'b1}}) n.run[i] = c.run[i] + DW'(1);
            if (n.run[i] == c.deb) begin
               nf[i] = din[i];
               n.run[i] = '0;
            end
         end else begin
            n.run[i] = '0;
         end
      end
      n.prev   = c.filt;
      n.filt   = nf;
      n.maip   = |(c.pend & c.ie);
      n.rvalid = rd;
      n.rdata  = '0;
      if (rd) begin
         case (a)
            3'd0:    n.rdata = XW'(c.en);
            3'd1:    n.rdata = XW'(c.out);
            3'd2:    n.rdata = XW'(c.filt);
            3'd3:    n.rdata = XW'(c.ie);
            3'd4:    n.rdata = XW'(c.mode);
            3'd5:    n.rdata = XW'(c.pend);
            3'd6:    n.rdata = XW'(c.deb);
            default: n.rdata = '0;
         endcase
      end
      n.pend = (c.pend & ~((wr && a == 3'd5) ? wd[N-1:0] : '0)) | ev;
      if (wr) begin
         case (a)
            3'd0:    n.en   = wd[N-1:0];
            3'd1:    n.out  = wd[N-1:0];
            3'd3:    n.ie   = wd[N-1:0];
            3'd4:    n.mode = wd[2*N-1:0];
            3'd6:    n.deb  = wd[DW-1:0];
            default: ;
         endcase
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= '0;
      else        m <= model_next(m, gpio_in, bus_wr, bus_rd, bus_addr, bus_wdata);
   end

   task automatic bus_write(input logic [2:0] a, input logic [XW-1:0] d);
      bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
      @(negedge clk);
      bus_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [XW-1:0] d, output logic v);
      bus_addr = a; bus_rd = 1'b1;
      @(negedge clk);
      bus_rd = 1'b0;
      d = bus_rdata; v = bus_rvalid;
   endtask

   task automatic test_reset();
      logic [XW-1:0] d; logic v;
      reset = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = '0; bus_wdata = '0;
      gpio_in = N'($urandom);
      repeat (3) @(negedge clk);
      n_cmp++; if (gpio_oe !== '0 || gpio_out !== '0) begin n_err++; $display("FAIL rst_hold_pads oe=%h out=%h exp=0", gpio_oe, gpio_out); end
      gpio_in = '0; reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (gpio_oe !== '0) begin n_err++; $display("FAIL rst_oe got=%h exp=0", gpio_oe); end
      n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL rst_out got=%h exp=0", gpio_out); end
      n_cmp++; if (maip !== 1'b0) begin n_err++; $display("FAIL rst_maip got=%b exp=0", maip); end
      n_cmp++; if (bus_rvalid !== 1'b0 || bus_rdata !== '0) begin n_err++; $display("FAIL rst_rd rvalid=%b rdata=%h exp=0", bus_rvalid, bus_rdata); end
      for (int a = 0; a < 7; a++) begin
         bus_read(3'(a), d, v);
         n_cmp++; if (v !== 1'b1 || d !== '0) begin n_err++; $display("FAIL rst_reg%0d rvalid=%b rdata=%h exp rvalid=1 rdata=0", a, v, d); end
      end
      @(negedge clk);
      n_cmp++; if (bus_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid_pulse got=%b exp=0", bus_rvalid); end
   endtask

   task automatic test_output();
      logic [XW-1:0] d; logic v;
      bus_write(3'd0, 32'hF0);
      n_cmp++; if (gpio_oe !== 8'hF0) begin n_err++; $display("FAIL out_oe got=%h exp=f0", gpio_oe); end
      bus_write(3'd1, 32'hFFFF_FFA5);
      n_cmp++; if (gpio_out !== 8'hA5) begin n_err++; $display("FAIL out_val got=%h exp=a5", gpio_out); end
      bus_read(3'd1, d, v);
      n_cmp++; if (d !== 32'h0000_00A5 || v !== 1'b1) begin n_err++; $display("FAIL out_read got=%h v=%b exp=000000a5", d, v); end
      bus_write(3'd0, 32'h0);
      bus_write(3'd1, 32'h0);
   endtask

   task automatic test_rising();
      logic [XW-1:0] d; logic v;
      bus_write(3'd3, 32'h01);
      repeat (4) @(negedge clk);
      gpio_in[0] = 1'b1;
      for (int k = 1; k <= SS + 4; k++) begin
         @(negedge clk);
         n_cmp++; if (maip !== (k >= SS + 3)) begin n_err++; $display("FAIL rise_maip k=%0d got=%b exp=%b", k, maip, (k >= SS + 3)); end
      end
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL rise_pend got=%h exp=1", d); end
      bus_write(3'd5, 32'h1);
      n_cmp++; if (maip !== 1'b1) begin n_err++; $display("FAIL rise_maip_hold got=%b exp=1", maip); end
      @(negedge clk);
      n_cmp++; if (maip !== 1'b0) begin n_err++; $display("FAIL rise_maip_clr got=%b exp=0", maip); end
      gpio_in[0] = 1'b0;
      repeat (SS + 3) @(negedge clk);
   endtask

   task automatic test_debounce();
      logic [XW-1:0] d; logic v;
      bus_write(3'd6, 32'd5);
      gpio_in[3] = 1'b1;
      repeat (4) @(negedge clk);
      gpio_in[3] = 1'b0;
      repeat (12) @(negedge clk);
      bus_read(3'd2, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL deb_glitch_in got=%h exp=0", d); end
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL deb_glitch_pend got=%h exp=0", d); end
      gpio_in[3] = 1'b1;
      repeat (SS + 4) @(negedge clk);
      bus_read(3'd2, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL deb_early_in got=%h exp=0", d); end
      bus_read(3'd2, d, v);
      n_cmp++; if (d !== 32'h8) begin n_err++; $display("FAIL deb_stable_in got=%h exp=8", d); end
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h8) begin n_err++; $display("FAIL deb_stable_pend got=%h exp=8", d); end
      gpio_in = '0;
      bus_write(3'd6, 32'd0);
      repeat (SS + 3) @(negedge clk);
      bus_write(3'd5, 32'hFF);
   endtask

   task automatic test_level();
      logic [XW-1:0] d; logic v;
      bus_write(3'd4, 32'h30);
      bus_write(3'd3, 32'h04);
      gpio_in[2] = 1'b1;
      repeat (SS + 4) @(negedge clk);
      n_cmp++; if (maip !== 1'b1) begin n_err++; $display("FAIL lvl_maip_set got=%b exp=1", maip); end
      bus_write(3'd5, 32'h04);
      repeat (2) @(negedge clk);
      bus_read(3'd5, d, v);
      n_cmp++; if (d[2] !== 1'b1) begin n_err++; $display("FAIL lvl_pend_sticky got=%h exp bit2=1", d); end
      n_cmp++; if (maip !== 1'b1) begin n_err++; $display("FAIL lvl_maip_sticky got=%b exp=1", maip); end
      gpio_in[2] = 1'b0;
      repeat (SS + 3) @(negedge clk);
      bus_write(3'd5, 32'h04);
      @(negedge clk);
      n_cmp++; if (maip !== 1'b0) begin n_err++; $display("FAIL lvl_maip_clr got=%b exp=0", maip); end
      bus_write(3'd4, 32'h0);
      gpio_in[5] = 1'b1;
      repeat (SS + 1) @(negedge clk);
      bus_write(3'd5, 32'h20);
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h20) begin n_err++; $display("FAIL collide_pend got=%h exp=20", d); end
      bus_write(3'd5, 32'hFF);
      gpio_in = '0;
      repeat (SS + 3) @(negedge clk);
   endtask

   task automatic test_mask();
      logic [XW-1:0] d; logic v;
      bus_write(3'd0, 32'h02);
      for (int t = 0; t < 4; t++) begin
         gpio_in[1] = ~gpio_in[1];
         repeat (4) @(negedge clk);
      end
      gpio_in[1] = 1'b0;
      repeat (SS + 4) @(negedge clk);
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL dir_pend got=%h exp=0", d); end
      bus_write(3'd0, 32'h80);
      bus_write(3'd3, 32'h0);
      gpio_in[4] = 1'b1;
      repeat (SS + 4) @(negedge clk);
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL mask_pend got=%h exp=10", d); end
      n_cmp++; if (maip !== 1'b0) begin n_err++; $display("FAIL mask_maip got=%b exp=0", maip); end
      bus_write(3'd3, 32'h10);
      n_cmp++; if (maip !== 1'b0) begin n_err++; $display("FAIL unmask_maip_early got=%b exp=0", maip); end
      @(negedge clk);
      n_cmp++; if (maip !== 1'b1) begin n_err++; $display("FAIL unmask_maip got=%b exp=1", maip); end
      n_cmp++; if (gpio_oe !== 8'h80) begin n_err++; $display("FAIL pre_rst_oe got=%h exp=80", gpio_oe); end
      reset = 1'b0;
      #1;
      n_cmp++; if (maip !== 1'b0 || gpio_oe !== '0) begin n_err++; $display("FAIL async_rst maip=%b oe=%h exp=0", maip, gpio_oe); end
      gpio_in = '0;
      @(negedge clk);
      reset = 1'b1;
      bus_read(3'd5, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_pend got=%h exp=0", d); end
      bus_read(3'd3, d, v);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_ie got=%h exp=0", d); end
   endtask

   task automatic test_random();
      int op;
      logic [2:0] a;
      for (int c = 0; c < 3000; c++) begin
         n_cmp++; if (gpio_oe !== m.en) begin n_err++; $display("FAIL rnd_oe cyc=%0d got=%h exp=%h", c, gpio_oe, m.en); end
         n_cmp++; if (gpio_out !== m.out) begin n_err++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", c, gpio_out, m.out); end
         n_cmp++; if (maip !== m.maip) begin n_err++; $display("FAIL rnd_maip cyc=%0d got=%b exp=%b", c, maip, m.maip); end
         n_cmp++; if (bus_rvalid !== m.rvalid) begin n_err++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, bus_rvalid, m.rvalid); end
         if (m.rvalid) begin
            n_cmp++; if (bus_rdata !== m.rdata) begin n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, bus_rdata, m.rdata); end
         end
         gpio_in = gpio_in ^ N'($urandom & $urandom & $urandom & $urandom);
         op = $urandom_range(0, 9);
         a  = 3'($urandom_range(0, 7));
         bus_addr  = a;
         bus_wdata = (a == 3'd6) ? XW'($urandom_range(0, 4)) :
                     (a == 3'd0) ? ($urandom & $urandom) : $urandom;
         bus_wr = (op < 3) || (op == 6);
         bus_rd = (op >= 3) && (op <= 6);
         @(negedge clk);
      end
      bus_wr = 1'b0;
      bus_rd = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      gpio_in = '0;
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_output();
      test_rising();
      test_debounce();
      test_level();
      test_mask();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
